// File: rtl/free_memory.sv
// free_memory: releases a BLOCK_WORDS-word record back to the free pool.
// A request gives the record base address. The block checks that the address
// is aligned and nonzero, reads the header and checks the allocated flag
// (bit DATA_W-1). When SCRUB=1 it then zeroes body words 1..BLOCK_WORDS-1.
// The header is cleared last, so an interrupted free leaves the record allocated.
//
// Ports:
//   clock, resetn      system clock; asynchronous active-low reset
//   free_req           request, sampled only while idle
//   free_addr          record base address, latched on accept
//   busy               high whenever not idle
//   done               one-cycle completion pulse
//   err                0 ok, 1 misaligned, 2 address 0, 3 not allocated
//   free_count         successful frees, wraps at 2^16
//   ram_address        RAM word address (registered)
//   ram_data           RAM write data, always zero
//   ram_wren           RAM write enable (registered), only in SCRUB/HDR
//   ram_q              RAM read data
module free_memory #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 32,  // power of two, >= 2
    parameter int RD_LAT      = 2,   // 1..7
    parameter int SCRUB       = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              free_req,
    input  logic [ADDR_W-1:0] free_addr,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [15:0]       free_count,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_CHECK, S_SCRUB, S_HDR, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [2:0]        wait_q, wait_d;
    logic [1:0]        err_q, err_d;
    logic              done_q, done_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wren_q, wren_d;

    // Only the allocated flag of the header is examined.
    logic unused_q_bits;
    assign unused_q_bits = ^ram_q[DATA_W-2:0];

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        off_d   = off_q;
        wait_d  = wait_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        addr_d  = '0;
        wren_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (free_req) begin
                    base_d = free_addr;
                    if (free_addr[OFF_W-1:0] != '0) begin
                        err_d   = 2'd1;
                        state_d = S_DONE;
                    end else if (free_addr == '0) begin
                        err_d   = 2'd2;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 2'd0;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                wait_d  = 3'(RD_LAT);
                state_d = S_WAIT;
            end
            // The address is a register, so it reaches the RAM one cycle
            // after it is computed. WAIT runs RD_LAT cycles, and CHECK then
            // sees the header word while the address is still held at base.
            S_WAIT: begin
                if (wait_q == 3'd1) state_d = S_CHECK;
                else                wait_d  = wait_q - 3'd1;
            end
            S_CHECK: begin
                if (!ram_q[DATA_W-1]) begin
                    err_d   = 2'd3;
                    state_d = S_DONE;
                end else if (SCRUB != 0) begin
                    off_d   = OFF_W'(1);
                    state_d = S_SCRUB;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_SCRUB: begin
                off_d = off_q + OFF_W'(1);
                if (off_q == OFF_LAST) state_d = S_HDR;
            end
            S_HDR: begin
                cnt_d   = cnt_q + 16'd1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // RAM controls and done are registered from the next state, so each
        // one is asserted in the same cycle as the state it belongs to.
        case (state_d)
            S_READ, S_WAIT, S_CHECK: addr_d = base_d;
            S_SCRUB: begin
                // Alignment guarantees the OR cannot carry out of the record.
                addr_d = base_d | {{(ADDR_W-OFF_W){1'b0}}, off_d};
                wren_d = 1'b1;
            end
            S_HDR: begin
                addr_d = base_d;
                wren_d = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            off_q   <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            off_q   <= off_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wren_q  <= wren_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign free_count  = cnt_q;
    assign ram_address = addr_q;
    assign ram_data    = '0;
    assign ram_wren    = wren_q;

endmodule

// File: tb/tb_free_memory.sv
// Testbench for free_memory. dut0 uses SCRUB=1 and RD_LAT=2. dut1 uses
// SCRUB=0 and RD_LAT=1. Each instance has its own RAM model with a pipelined
// read. A shadow image of each memory is updated from the free rules. The
// bench checks latency, err, free_count, the RAM write log and the final
// contents of every record it touches.
module tb_free_memory;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [9:0]  fa = '0;
    logic        busy0, done0, we0, busy1, done1, we1;
    logic [1:0]  err0, err1;
    logic [15:0] fc0, fc1;
    logic [9:0]  ra0, ra1;
    logic [31:0] rd0, rd1, q0, q1;

    always #5 clk = ~clk;

    free_memory #(.ADDR_W(10), .DATA_W(32), .BLOCK_WORDS(32), .RD_LAT(2), .SCRUB(1)) dut0 (
        .clock(clk), .resetn(rstn), .free_req(req0), .free_addr(fa),
        .busy(busy0), .done(done0), .err(err0), .free_count(fc0),
        .ram_address(ra0), .ram_data(rd0), .ram_wren(we0), .ram_q(q0));

    free_memory #(.ADDR_W(10), .DATA_W(32), .BLOCK_WORDS(32), .RD_LAT(1), .SCRUB(0)) dut1 (
        .clock(clk), .resetn(rstn), .free_req(req1), .free_addr(fa),
        .busy(busy1), .done(done1), .err(err1), .free_count(fc1),
        .ram_address(ra1), .ram_data(rd1), .ram_wren(we1), .ram_q(q1));

    // RAM models, write logs and bench-side block fill port
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    logic [9:0]  ap0 [2];
    logic [9:0]  ap1;
    logic [9:0]  wq0 [$];
    logic [9:0]  wq1 [$];
    int          act0 = 0, act1 = 0;
    logic        fill = 1'b0, fsel = 1'b0;
    logic [9:0]  fbase = '0;
    logic [31:0] fhdr = '0, fbody = '0;

    always @(posedge clk) begin
        ap0[0] <= ra0;
        ap0[1] <= ap0[0];
        ap1    <= ra1;
        if (we0) begin mem0[ra0] <= rd0; wq0.push_back(ra0); end
        if (we1) begin mem1[ra1] <= rd1; wq1.push_back(ra1); end
        if (ra0 != '0 || we0) act0 <= act0 + 1;
        if (ra1 != '0 || we1) act1 <= act1 + 1;
        if (fill)
            for (int i = 0; i < 32; i++) begin
                if (fsel) mem1[10'(fbase + 10'(i))] <= (i == 0) ? fhdr : fbody;
                else      mem0[10'(fbase + 10'(i))] <= (i == 0) ? fhdr : fbody;
            end
    end
    assign q0 = mem0[ap0[1]];
    assign q1 = mem1[ap1];

    // Reference state
    logic [31:0] exp0 [1024];
    logic [31:0] exp1 [1024];
    int          cnt [2];
    int          vecs = 0;
    int          errs = 0;

    task automatic preload(input bit sel, input logic [9:0] base,
                           input logic [31:0] hdr, input logic [31:0] body);
        fsel = sel; fbase = base; fhdr = hdr; fbody = body; fill = 1'b1;
        @(negedge clk);
        fill = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (sel) exp1[10'(base + 10'(i))] = (i == 0) ? hdr : body;
            else     exp0[10'(base + 10'(i))] = (i == 0) ? hdr : body;
        end
    endtask

    task automatic check_block(input bit sel, input logic [9:0] blk, input string tag);
        int diffs;
        logic [31:0] g, w;
        diffs = 0;
        for (int i = 0; i < 32; i++) begin
            g = sel ? mem1[10'(blk + 10'(i))] : mem0[10'(blk + 10'(i))];
            w = sel ? exp1[10'(blk + 10'(i))] : exp0[10'(blk + 10'(i))];
            if (g !== w) diffs++;
        end
        vecs++;
        if (diffs != 0) begin
            errs++;
            $display("FAIL %s mem dut%0d block %0d: %0d words differ, want 0", tag, sel, blk, diffs);
        end
    endtask

    // Starts from a negedge with the DUT idle and returns on the idle negedge
    // after done, so back-to-back calls accept in the cycle following done.
    task automatic do_free(input bit sel, input logic [9:0] a, input int poke,
                           input logic [9:0] pa, input string tag);
        int rl, sc, cyc, exp_lat, n, n_exp, w_start, a_start, a_now, bad;
        logic [1:0]  exp_err, g_err;
        logic [9:0]  blk, wa, want;
        logic [31:0] hdr;
        logic        got_done;
        rl = sel ? 1 : 2;
        sc = sel ? 0 : 1;
        blk = a & 10'h3e0;
        hdr = sel ? exp1[a] : exp0[a];
        if (a[4:0] != 5'd0)   begin exp_err = 2'd1; exp_lat = 1; end
        else if (a == 10'd0)  begin exp_err = 2'd2; exp_lat = 1; end
        else if (!hdr[31])    begin exp_err = 2'd3; exp_lat = 3 + rl; end
        else begin
            exp_err = 2'd0;
            exp_lat = 4 + rl + sc * 31;
            cnt[sel] = (cnt[sel] + 1) % 65536;
            for (int i = 0; i < 32; i++)
                if (i == 0 || sc == 1) begin
                    if (sel) exp1[10'(a + 10'(i))] = '0;
                    else     exp0[10'(a + 10'(i))] = '0;
                end
        end
        w_start = sel ? wq1.size() : wq0.size();
        a_start = sel ? act1 : act0;

        fa = a;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (sel) req1 = (cyc == poke); else req0 = (cyc == poke);
            fa = (cyc == poke) ? pa : 10'($urandom);
            got_done = sel ? done1 : done0;
        end

        vecs++;
        if (!got_done) begin
            errs++;
            $display("FAIL %s timeout dut%0d addr %0d: no done in %0d cycles, want cycle %0d", tag, sel, a, cyc, exp_lat);
        end else if (cyc != exp_lat) begin
            errs++;
            $display("FAIL %s latency dut%0d addr %0d: got %0d want %0d", tag, sel, a, cyc, exp_lat);
        end
        g_err = sel ? err1 : err0;
        vecs++;
        if (g_err !== exp_err) begin
            errs++;
            $display("FAIL %s err dut%0d addr %0d: got %0d want %0d", tag, sel, a, g_err, exp_err);
        end
        vecs++;
        if ((sel ? fc1 : fc0) !== 16'(cnt[sel])) begin
            errs++;
            $display("FAIL %s free_count dut%0d: got %0d want %0d", tag, sel, sel ? fc1 : fc0, cnt[sel]);
        end
        vecs++;
        if ((sel ? busy1 : busy0) !== 1'b1) begin
            errs++;
            $display("FAIL %s busy_at_done dut%0d: got %b want 1", tag, sel, sel ? busy1 : busy0);
        end

        @(negedge clk);
        vecs++;
        if ((sel ? busy1 : busy0) !== 1'b0 || (sel ? done1 : done0) !== 1'b0) begin
            errs++;
            $display("FAIL %s idle_after dut%0d: busy %b done %b want 0 0", tag, sel,
                     sel ? busy1 : busy0, sel ? done1 : done0);
        end

        // Write log: body offsets 1..31 in order (when scrubbing), header last
        n = (sel ? wq1.size() : wq0.size()) - w_start;
        n_exp = (exp_err == 2'd0) ? (sc ? 32 : 1) : 0;
        bad = (n != n_exp) ? 1 : 0;
        for (int k = 0; k < n && k < n_exp && bad == 0; k++) begin
            wa = sel ? wq1[w_start + k] : wq0[w_start + k];
            want = (k == n_exp - 1) ? a : 10'(a + 10'(k + 1));
            if (wa !== want) bad = 1;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL %s writes dut%0d addr %0d: %0d writes logged, want %0d ending at header", tag, sel, a, n, n_exp);
        end
        if (exp_err == 2'd1 || exp_err == 2'd2) begin
            a_now = sel ? act1 : act0;
            vecs++;
            if (a_now != a_start) begin
                errs++;
                $display("FAIL %s ram_activity dut%0d addr %0d: got %0d active cycles want 0", tag, sel, a, a_now - a_start);
            end
        end
        check_block(sel, blk, tag);
        if (poke != 0) check_block(sel, pa & 10'h3e0, tag);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #1;
        vecs++;
        if ({busy0, done0, err0, fc0, ra0, rd0, we0} !== '0 ||
            {busy1, done1, err1, fc1, ra1, rd1, we1} !== '0) begin
            errs++;
            $display("FAIL reset_values: dut0 %h dut1 %h want 0",
                     {busy0, done0, err0, fc0, ra0, rd0, we0}, {busy1, done1, err1, fc1, ra1, rd1, we1});
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        cnt[0] = 0;
        cnt[1] = 0;
        for (int b = 0; b < 32; b++) begin
            preload(1'b0, 10'(b * 32), 32'h8000_0000, 32'hDEAD_BEEF);
            preload(1'b1, 10'(b * 32), 32'h8000_0000, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_free_alloc();
        preload(1'b0, 10'd64, 32'h8000_0000, 32'hDEAD_BEEF);
        do_free(1'b0, 10'd64, 0, 10'd0, "free64");
    endtask

    task automatic test_double_free();
        preload(1'b0, 10'd128, 32'h0000_0000, 32'h1234_5678);
        do_free(1'b0, 10'd128, 0, 10'd0, "double_free");
        preload(1'b1, 10'd160, 32'h7FFF_FFFF, 32'h5555_AAAA);
        do_free(1'b1, 10'd160, 0, 10'd0, "double_free_s0");
    endtask

    task automatic test_bad_addr();
        do_free(1'b0, 10'd70, 0, 10'd0, "misaligned");
        do_free(1'b0, 10'd0,  0, 10'd0, "zero_addr");
        do_free(1'b1, 10'd97, 0, 10'd0, "misaligned_s0");
    endtask

    task automatic test_busy_ignore();
        preload(1'b0, 10'd64,  32'h8000_0001, 32'hCAFE_F00D);
        preload(1'b0, 10'd256, 32'h8000_0002, 32'h0BAD_F00D);
        do_free(1'b0, 10'd64, 10, 10'd256, "busy_ignore");
        vecs++;
        if (mem0[256][31] !== 1'b1) begin
            errs++;
            $display("FAIL busy_ignore hdr256: got %h want bit31 set", mem0[256]);
        end
    endtask

    task automatic test_scrub0();
        preload(1'b1, 10'd32, 32'h8000_0000, 32'hDEAD_BEEF);
        do_free(1'b1, 10'd32, 0, 10'd0, "scrub0_free32");
    endtask

    task automatic test_reset_mid_scrub();
        preload(1'b0, 10'd64, 32'h8000_0000, 32'hDEAD_BEEF);
        fa = 10'd64;
        req0 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            req0 = 1'b0;
        end
        rstn = 1'b0;
        #1;
        vecs++;
        if ({busy0, done0, err0, fc0, ra0, rd0, we0} !== '0 || fc1 !== 16'd0) begin
            errs++;
            $display("FAIL midreset_outputs: dut0 %h fc1 %0d want 0",
                     {busy0, done0, err0, fc0, ra0, rd0, we0}, fc1);
        end
        vecs++;
        if (mem0[64] !== 32'h8000_0000 || mem0[79] !== 32'h0 || mem0[80] !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL midreset_mem: hdr %h w79 %h w80 %h want 80000000 0 deadbeef",
                     mem0[64], mem0[79], mem0[80]);
        end
        cnt[0] = 0;
        cnt[1] = 0;
        for (int i = 1; i <= 15; i++) exp0[10'(64 + i)] = '0;
        @(negedge clk);
        rstn = 1'b1;
        do_free(1'b0, 10'd64, 0, 10'd0, "reissue");
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            bit s;
            int b;
            logic [9:0] a;
            s = 1'($urandom);
            b = $urandom_range(0, 31);
            if ($urandom_range(0, 2) == 0)
                preload(s, 10'(b * 32), {1'b1, 31'($urandom)}, $urandom);
            a = 10'(b * 32);
            if ($urandom_range(0, 4) == 0) a = a | 10'($urandom_range(1, 31));
            do_free(s, a, 0, 10'd0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_free_alloc();
        test_double_free();
        test_bad_addr();
        test_busy_ignore();
        test_scrub0();
        test_reset_mid_scrub();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
